spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//  SPI mode-0 (CPOL=0, CPHA=0) slave endpoint, the peer of the master-side SPI_CLK divider.
//  SPI_CLK, SS_n and MOSI are asynchronous; all are oversampled in the PClK domain.
//  Deserialises MOSI into DATA_W-bit words and serialises a buffered TX word onto MISO, MSB first.
//  Sits between the SPI pins and the local register/APB side.
// PARAMETERS
//  DATA_W       8  word length in bits (2..32)
//  SYNC_STAGES  2  synchroniser depth on SPI_CLK/SS_n/MOSI (>=2)
// PORTS
//  PClK      in   1       system clock; sole clock of the block
//  PRESETn   in   1       asynchronous active-low reset
//  SPI_CLK   in   1       serial clock from master; idle low
//  SS_n      in   1       slave select, active low
//  MOSI      in   1       serial data from master
//  MISO      out  1       serial data to master; 0 when not selected
//  MISO_OE   out  1       pad output enable; 1 while SS_n (synchronised) is low
//  TX_DATA   in   DATA_W  next word to transmit
//  TX_WR     in   1       write TX_DATA into TX holding buffer (honoured only when TX_READY=1)
//  TX_READY  out  1       TX holding buffer empty
//  RX_DATA   out  DATA_W  last complete received word; held until the next word completes
//  RX_VALID  out  1       one-PClK pulse: RX_DATA updated
//  UNDERRUN  out  1       one-PClK pulse: a TX load found the buffer empty; zeros are sent
//  BUSY      out  1       1 while selected (state ACTIVE)
// BEHAVIOUR
//  Reset (async, PRESETn=0): MISO=0, MISO_OE=0, TX_READY=1, RX_DATA=0, RX_VALID=0, UNDERRUN=0,
//   BUSY=0, bit count=0, shift registers=0, state=IDLE. Asserting reset mid-word empties the TX
//   buffer and discards the partial word.
//  Input sync: SYNC_STAGES flops per input, then 1 flop for edge detect.
//   Edge seen SYNC_STAGES+1 PClK after the pin. SPI_CLK high and low phases must each be >=3 PClK.
//  FSM IDLE -> ACTIVE when synchronised SS_n falls.
//   On that transition: tx_shift <= buffer (buffer then empty, TX_READY=1), else zeros + UNDERRUN.
//   ACTIVE -> IDLE when synchronised SS_n rises, any bit count. A partial word is discarded with no
//   RX_VALID and the count is cleared; an untransmitted buffer word is kept.
//  ACTIVE, SPI_CLK rising edge: rx_shift <= {rx_shift[DATA_W-2:0], MOSI_sync}; bit count +1.
//   On the DATA_W-th rise the count wraps to 0 and the next cycle gives RX_DATA <= full word
//   (includes that bit) and RX_VALID=1 for exactly one PClK.
//  ACTIVE, SPI_CLK falling edge: if bit count!=0, tx_shift <= tx_shift<<1.
//   If bit count==0 (word boundary), reload tx_shift from the buffer, or zeros + UNDERRUN.
//   Back-to-back words continue while SS_n stays low.
//  MISO = tx_shift[DATA_W-1] registered, gated to 0 when not ACTIVE; MISO_OE = BUSY.
//  TX buffer: TX_WR with TX_READY=1 captures TX_DATA; TX_READY drops the next cycle.
//   TX_WR with TX_READY=0 is ignored (no overwrite).
//   Load and TX_WR in the same cycle: the load sees the buffer as empty (UNDERRUN).
//   The written word stays in the buffer for the next load.
//  SPI_CLK edges while IDLE are ignored. An SS_n fall coincident with an SPI_CLK edge: only the
//   SS_n transition is processed that cycle.
// TESTING
//  Single word: TX_WR 0xA5; SS_n low; 8 clocks MOSI=0x3C -> MISO bits 1,0,1,0,0,1,0,1;
//   RX_DATA=0x3C; one RX_VALID; UNDERRUN=0.
//  Back-to-back: load 0x81, SS_n low, after 1st word write 0x7E, 16 clocks MOSI 0x12,0x34
//   -> MISO 0x81 then 0x7E; RX_VALID twice with 0x12 then 0x34.
//  Underrun: no TX_WR, SS_n low, 8 clocks -> UNDERRUN pulse at select; MISO=0 for all bits;
//   RX still received.
//  Abort: SS_n high after 5 clocks -> no RX_VALID, RX_DATA unchanged, BUSY=0;
//   the next full word is received correctly.
//  Buffer full: two TX_WR (0x11 then 0x22) without a load -> TX_READY=0; 0x11 transmitted, 0x22 lost.
//  Reset mid-word: PRESETn low after 3 clocks -> all outputs at reset values immediately;
//   TX_READY=1 after release.

Source files
------------

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// spi_slave_if : SPI mode-0 slave, PClK-oversampled, with a one-word TX buffer
// Revision     : 1.0
// ============================================================================
module spi_slave_if #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PClK,
  input  logic              PRESETn,
  input  logic              SPI_CLK,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_WR,
  output logic              TX_READY,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              UNDERRUN,
  output logic              BUSY
);

  localparam int              c_cnt_w    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_ss_d;

  state_t                 r_state;
  logic [c_cnt_w-1:0]     r_bit_cnt;
  logic [DATA_W-1:0]      r_rx_shift;
  logic [DATA_W-1:0]      r_tx_shift;
  logic [DATA_W-1:0]      r_tx_buf;
  logic                   r_tx_ready;
  logic [DATA_W-1:0]      r_rx_data;
  logic                   r_rx_valid;
  logic                   r_underrun;
  logic                   r_busy;
  logic                   r_miso;

  logic                   w_sclk;
  logic                   w_ss;
  logic                   w_mosi;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_ss_fall;
  logic                   w_ss_rise;
  logic                   w_load;
  logic                   w_shift;
  logic [DATA_W-1:0]      w_rx_next;

  // SS_n chain resets high so releasing reset never looks like a select
  always_ff @(posedge PClK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_fall   = ~w_ss & r_ss_d;
  assign w_ss_rise   = w_ss & ~r_ss_d;
  assign w_rx_next   = {r_rx_shift[DATA_W-2:0], w_mosi};

  // Deselect outranks any coincident clock edge, so a word boundary at the
  // very end of a frame does not pull the next buffered word.
  assign w_load  = ((r_state == ST_IDLE) && w_ss_fall) ||
                   ((r_state == ST_ACTIVE) && !w_ss_rise && w_sclk_fall && (r_bit_cnt == '0));
  assign w_shift = (r_state == ST_ACTIVE) && !w_ss_rise && w_sclk_fall && (r_bit_cnt != '0);

  always_ff @(posedge PClK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_tx_buf   <= '0;
      r_tx_ready <= 1'b1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_busy     <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_miso     <= r_tx_shift[DATA_W-1];

      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          if (w_ss_fall) begin
            r_state <= ST_ACTIVE;
            r_busy  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (w_ss_rise) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
          end else if (w_sclk_rise) begin
            r_rx_shift <= w_rx_next;
            if (r_bit_cnt == c_last_bit) begin
              r_bit_cnt  <= '0;
              r_rx_data  <= w_rx_next;
              r_rx_valid <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
            end
          end
        end
      endcase

      if (w_load) begin
        if (!r_tx_ready) begin
          r_tx_shift <= r_tx_buf;
          r_tx_ready <= 1'b1;
        end else begin
          r_tx_shift <= '0;
          r_underrun <= 1'b1;
        end
      end else if (w_shift) begin
        r_tx_shift <= r_tx_shift << 1;
      end

      // A load that found the buffer empty still lets this write land
      if (TX_WR && r_tx_ready) begin
        r_tx_buf   <= TX_DATA;
        r_tx_ready <= 1'b0;
      end
    end
  end

  assign MISO     = r_miso & r_busy;
  assign MISO_OE  = r_busy;
  assign BUSY     = r_busy;
  assign TX_READY = r_tx_ready;
  assign RX_DATA  = r_rx_data;
  assign RX_VALID = r_rx_valid;
  assign UNDERRUN = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ============================================================================
// tb_spi_slave_if : randomized SPI master against a frame-level reference model
// Revision        : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_spi_slave_if;

  localparam int DW = 8;

  logic          PClK    = 1'b0;
  logic          PRESETn = 1'b0;
  logic          SPI_CLK = 1'b0;
  logic          SS_n    = 1'b1;
  logic          MOSI    = 1'b0;
  logic          TX_WR   = 1'b0;
  logic [DW-1:0] TX_DATA = '0;
  logic          MISO;
  logic          MISO_OE;
  logic          TX_READY;
  logic [DW-1:0] RX_DATA;
  logic          RX_VALID;
  logic          UNDERRUN;
  logic          BUSY;

  always #5 PClK = ~PClK;

  spi_slave_if #(.DATA_W(DW), .SYNC_STAGES(2)) u_dut (
    .PClK     (PClK),
    .PRESETn  (PRESETn),
    .SPI_CLK  (SPI_CLK),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .MISO_OE  (MISO_OE),
    .TX_DATA  (TX_DATA),
    .TX_WR    (TX_WR),
    .TX_READY (TX_READY),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .UNDERRUN (UNDERRUN),
    .BUSY     (BUSY)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one-entry TX buffer and last received word
  bit            m_full    = 1'b0;
  logic [DW-1:0] m_buf     = '0;
  logic [DW-1:0] m_rx_last = '0;

  logic [DW-1:0] g_mosi    [4];
  bit            g_mid_en  [4];
  logic [DW-1:0] g_mid_val [4];

  logic [DW-1:0] rx_q[$];
  int            ur_seen = 0;

  always @(negedge PClK) begin
    if (PRESETn) begin
      if (RX_VALID) rx_q.push_back(RX_DATA);
      if (UNDERRUN) ur_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge PClK);
  endtask

  task automatic tx_write(input logic [DW-1:0] v);
    if (!m_full) begin
      m_full = 1'b1;
      m_buf  = v;
    end
    TX_DATA = v;
    TX_WR   = 1'b1;
    tick(1);
    TX_WR   = 1'b0;
  endtask

  task automatic set_words(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                           input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    g_mosi[0] = w0; g_mosi[1] = w1; g_mosi[2] = w2; g_mosi[3] = w3;
    for (int k = 0; k < 4; k++) begin
      g_mid_en[k]  = 1'b0;
      g_mid_val[k] = '0;
    end
  endtask

  // pre_mode: 0 none, 1 write before select, 2 write in the select-load cycle
  task automatic xfer(input int nbits, input int pre_mode, input logic [DW-1:0] pre_val);
    logic [DW-1:0] ld;
    logic [31:0]   got;
    logic [31:0]   exp;
    logic [DW-1:0] exp_q[$];
    int            exp_ur;
    bit            oe_ok;
    bit            was_full;
    int            lo;
    int            hi;
    rx_q.delete();
    ur_seen = 0;
    exp_ur  = 0;
    got     = '0;
    exp     = '0;
    oe_ok   = 1'b1;
    if (pre_mode == 1) tx_write(pre_val);
    SS_n = 1'b0;
    if (pre_mode == 2) begin
      tick(2);
      TX_DATA = pre_val;
      TX_WR   = 1'b1;
      tick(1);
      TX_WR   = 1'b0;
      tick(3);
    end else begin
      tick(6);
    end
    was_full = m_full;
    if (m_full) begin
      ld = m_buf;
      m_full = 1'b0;
    end else begin
      ld = '0;
      exp_ur++;
    end
    if (pre_mode == 2 && !was_full) begin
      m_full = 1'b1;
      m_buf  = pre_val;
    end
    for (int i = 0; i < nbits; i++) begin
      int w;
      int b;
      w  = i / DW;
      b  = DW - 1 - (i % DW);
      lo = $urandom_range(3, 6);
      hi = $urandom_range(3, 6);
      MOSI = g_mosi[w][b];
      tick(lo);
      SPI_CLK = 1'b1;
      exp = {exp[30:0], ld[b]};
      if (b == 0) exp_q.push_back(g_mosi[w]);
      if (b == 0 && g_mid_en[w] && (i + 1 < nbits)) begin
        tick(1);
        tx_write(g_mid_val[w]);
        tick(hi - 2);
      end else begin
        tick(hi);
      end
      got   = {got[30:0], MISO};
      oe_ok = oe_ok & MISO_OE & BUSY;
      SPI_CLK = 1'b0;
      if (i == nbits - 1) SS_n = 1'b1;
      if (b == 0 && (i + 1 < nbits)) begin
        if (m_full) begin
          ld = m_buf;
          m_full = 1'b0;
        end else begin
          ld = '0;
          exp_ur++;
        end
      end
    end
    tick(8);
    check("rx_count", rx_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
      check("rx_word", rx_q[k], exp_q[k]);
    if (exp_q.size() > 0) m_rx_last = exp_q[exp_q.size()-1];
    check("rx_data", RX_DATA, m_rx_last);
    check("underrun", ur_seen, exp_ur);
    check("miso_bits", got, exp);
    check("oe_busy_active", oe_ok, 1);
    check("busy_idle", {MISO_OE, BUSY, MISO}, 3'b000);
    check("tx_ready", TX_READY, !m_full);
  endtask

  initial begin
    int nb;
    int r;
    set_words('0, '0, '0, '0);
    tick(3);
    check("rst_outputs", {MISO, MISO_OE, TX_READY, RX_VALID, UNDERRUN, BUSY}, 6'b001000);
    check("rst_rx_data", RX_DATA, 0);
    PRESETn = 1'b1;
    tick(4);

    // single word
    set_words(8'h3C, '0, '0, '0);
    xfer(8, 1, 8'hA5);

    // back-to-back with a write after the first word
    set_words(8'h12, 8'h34, '0, '0);
    g_mid_en[0] = 1'b1; g_mid_val[0] = 8'h7E;
    xfer(16, 1, 8'h81);

    // underrun
    set_words(8'hC7, '0, '0, '0);
    xfer(8, 0, '0);

    // abort after 5 clocks, then a clean word
    set_words(8'hF0, '0, '0, '0);
    xfer(5, 1, 8'h6D);
    set_words(8'h9B, '0, '0, '0);
    xfer(8, 1, 8'h4E);

    // buffer full: second write dropped
    tx_write(8'h11);
    tx_write(8'h22);
    check("tx_ready_full", TX_READY, 0);
    set_words(8'h5A, '0, '0, '0);
    xfer(8, 0, '0);

    // write landing in the same cycle as the select load
    set_words(8'h01, 8'h02, '0, '0);
    xfer(16, 2, 8'hB4);

    for (int it = 0; it < 25; it++) begin
      r  = $urandom_range(0, 9);
      nb = (r < 7) ? DW * $urandom_range(1, 3) : $urandom_range(1, 3 * DW - 1);
      set_words(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      for (int k = 0; k < 4; k++) begin
        g_mid_en[k]  = $urandom_range(0, 1) == 1;
        g_mid_val[k] = DW'($urandom);
      end
      xfer(nb, $urandom_range(0, 1), DW'($urandom));
    end

    // reset in the middle of a word with the TX buffer full
    set_words('0, '0, '0, '0);
    if (RX_DATA == '0) xfer(8, 0, '0);
    tx_write(8'hC3);
    SS_n = 1'b0;
    tick(6);
    m_full = 1'b0;
    tx_write(8'h5A);
    for (int i = 0; i < 3; i++) begin
      MOSI = $urandom_range(0, 1) == 1;
      tick(4);
      SPI_CLK = 1'b1;
      tick(4);
      SPI_CLK = 1'b0;
    end
    tick(2);
    PRESETn = 1'b0;
    #1;
    check("midrst_outputs", {MISO, MISO_OE, TX_READY, RX_VALID, UNDERRUN, BUSY}, 6'b001000);
    check("midrst_rx_data", RX_DATA, 0);
    SS_n    = 1'b1;
    SPI_CLK = 1'b0;
    tick(3);
    PRESETn = 1'b1;
    m_full    = 1'b0;
    m_rx_last = '0;
    tick(5);
    check("post_rst_ready", TX_READY, 1);
    check("post_rst_busy", BUSY, 0);
    set_words(8'hE1, '0, '0, '0);
    xfer(8, 1, 8'h96);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
